// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for CPU load/store traffic. Accepts one request at a
//   time over valid/ready and performs a byte, half or word access on internal
//   32-bit word storage. The response appears LATENCY cycles after the accept edge.
//   funct3 selects the access width and the load extension.
// Ports
//   clk, reset             clock and synchronous active-high reset
//   req_valid / req_ready  request handshake (ready is high only in IDLE)
//   req_we                 1 = store, 0 = load
//   req_funct3             000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata    little-endian byte address and store data
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata, rsp_err     extended load data (0 on store/error) and error flag
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    // RESP itself costs one cycle before rsp_valid rises, so WAIT covers LATENCY-1.
    localparam logic [3:0]  WAIT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [3:0]       lat_cnt;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      word;
    logic [31:0]      wr_word;
    logic [31:0]      ld_data;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic             err;
    logic             accept;
    logic [31:0]      pend_rdata;
    logic             pend_err;

    assign idx    = req_addr[IDX_W+1:2];
    assign lane   = req_addr[1:0];
    assign word   = mem[idx];
    assign accept = req_valid && req_ready && !reset;
    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        err = 1'b0;
        case (req_funct3)
            3'b000:  err = 1'b0;
            3'b001:  err = req_addr[0];
            3'b010:  err = |req_addr[1:0];
            3'b100:  err = req_we;
            3'b101:  err = req_we | req_addr[0];
            default: err = 1'b1;
        endcase
        // Upper address bits only matter here.
        if ({1'b0, req_addr} >= ADDR_LIMIT)
            err = 1'b1;
    end

    // Merge the store data into the current word so that unwritten lanes keep their value.
    always_comb begin
        wr_word = word;
        case (req_funct3[1:0])
            2'b00:   wr_word[{lane, 3'b000} +: 8]     = req_wdata[7:0];
            2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
            default: wr_word = req_wdata;
        endcase
    end

    always_comb begin
        case (req_funct3)
            3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  ld_data = {{16{half_v[15]}}, half_v};
            3'b100:  ld_data = {24'd0, byte_v};
            3'b101:  ld_data = {16'd0, half_v};
            default: ld_data = word;
        endcase
    end

    // Storage is not reset; a legal store commits on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err)
            mem[idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            lat_cnt    <= '0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend_rdata <= (err || req_we) ? 32'd0 : ld_data;
                        pend_err   <= err;
                        req_ready  <= 1'b0;
                        if (LATENCY <= 1) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0)
                        state <= RESP;
                    else
                        lat_cnt <= lat_cnt - 4'd1;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam int ND = 3;  // instance d has LATENCY d+1
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [ND-1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [ND-1:0][2:0]  req_funct3;
    logic [ND-1:0][31:0] req_addr, req_wdata, rsp_rdata;

    exp_t sb[$];
    int cyc = 0;
    int total = 0;
    int passed = 0;
    logic [ND-1:0] was_v = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: checks latency on the rising cycle, payload on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rsp_valid[d] && !was_v[d]) begin
                if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid[d]), 32'd0);
                else chk("latency", cyc, sb[0].acc + d + 1);
            end
            if (rsp_valid[d] && rsp_ready[d] && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_dut", d, e.d);
                chk("rsp_rdata", rsp_rdata[d], e.rdata);
                chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
            end
            was_v[d] = rsp_valid[d];
        end
    end

    task automatic drive(int d, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_valid[d]  = 1'b1;
    endtask

    task automatic issue(int d, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                         logic [31:0] exp_d, bit exp_e, bit track);
        int n = 0;
        drive(d, we, f3, a, wd);
        while (!req_ready[d] && n < 50) begin step(); n++; end
        if (!req_ready[d]) chk("accept_timeout", 32'(req_ready[d]), 32'd1);
        if (track) sb.push_back('{d, exp_d, exp_e, cyc + 1});
        step();
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_done(int d);
        int n = 0;
        while ((sb.size() != 0 || rsp_valid[d]) && n < 60) begin step(); n++; end
        chk("rsp_timeout", sb.size(), 0);
    endtask

    task automatic xfer(int d, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] exp_d, bit exp_e);
        issue(d, we, f3, a, wd, exp_d, exp_e, 1'b1);
        wait_done(d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '1;
        repeat (2) step();
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        end

        // Word store/load at LATENCY=1 and LATENCY=2
        xfer(0, 1, F_W, 32'h8, 32'hDEADBEEF, 32'h0, 0);
        xfer(0, 0, F_W, 32'h8, 32'h0, 32'hDEADBEEF, 0);
        xfer(1, 1, F_W, 32'h8, 32'hDEADBEEF, 32'h0, 0);
        xfer(1, 0, F_W, 32'h8, 32'h0, 32'hDEADBEEF, 0);

        // Byte lane store and sub-word loads
        xfer(1, 1, F_B, 32'h9, 32'h00000080, 32'h0, 0);
        xfer(1, 0, F_B, 32'h9, 32'h0, 32'hFFFFFF80, 0);
        xfer(1, 0, F_BU, 32'h9, 32'h0, 32'h00000080, 0);
        xfer(1, 0, F_W, 32'h8, 32'h0, 32'hDEAD80EF, 0);
        xfer(1, 0, F_H, 32'h8, 32'h0, 32'hFFFF80EF, 0);
        xfer(1, 0, F_HU, 32'hA, 32'h0, 32'h0000DEAD, 0);

        // Error cases leave storage alone
        xfer(1, 1, F_W, 32'h4, 32'h11223344, 32'h0, 0);
        xfer(1, 0, F_H, 32'h3, 32'h0, 32'h0, 1);
        xfer(1, 1, F_W, 32'h6, 32'h12345678, 32'h0, 1);
        xfer(1, 0, F_W, 32'd4096, 32'h0, 32'h0, 1);
        xfer(1, 0, F_BAD, 32'h4, 32'h0, 32'h0, 1);
        xfer(1, 1, F_BU, 32'h4, 32'hFFFFFFFF, 32'h0, 1);
        xfer(1, 0, F_W, 32'h4, 32'h0, 32'h11223344, 0);

        // Response stall with a second request waiting
        rsp_ready[1] = 1'b0;
        issue(1, 0, F_W, 32'h8, 32'h0, 32'hDEAD80EF, 0, 1'b1);
        drive(1, 0, F_W, 32'h4, 32'h0);
        n = 0;
        while (!rsp_valid[1] && n < 20) begin step(); n++; end
        repeat (5) begin
            step();
            chk("stall_valid", 32'(rsp_valid[1]), 32'd1);
            chk("stall_rdata", rsp_rdata[1], 32'hDEAD80EF);
            chk("stall_err", 32'(rsp_err[1]), 32'd0);
            chk("stall_req_ready", 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        step();
        chk("ready_after_hs", 32'(req_ready[1]), 32'd1);
        chk("valid_after_hs", 32'(rsp_valid[1]), 32'd0);
        sb.push_back('{1, 32'h11223344, 1'b0, cyc + 1});
        step();
        req_valid[1] = 1'b0;
        wait_done(1);

        // Half store into upper lanes, top-of-range word
        xfer(1, 1, F_H, 32'h6, 32'h0000A55A, 32'h0, 0);
        xfer(1, 0, F_W, 32'h4, 32'h0, 32'hA55A3344, 0);
        xfer(1, 1, F_W, 32'hFFC, 32'hCAFEF00D, 32'h0, 0);
        xfer(1, 0, F_W, 32'hFFC, 32'h0, 32'hCAFEF00D, 0);
        xfer(1, 0, F_H, 32'hFFE, 32'h0, 32'hFFFFCAFE, 0);

        // Reset while LATENCY=3 store is pending
        issue(2, 1, F_W, 32'h10, 32'h00000055, 32'h0, 0, 1'b0);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("mid_rst_req_ready", 32'(req_ready[2]), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        repeat (5) step();
        chk("mid_rst_no_rsp", 32'(rsp_valid[2]), 32'd0);
        xfer(2, 0, F_W, 32'h10, 32'h0, 32'h00000055, 0);

        repeat (3) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
